styler_scheduler: RTL and testbench

Sequencing controller for the styler datapath. It walks a text frame cell by cell and scanline by scanline, and fetches each cell's glyph row through a valid/ack handshake. It holds that row on the styler's bitmap input, captures the styled result, and serializes it MSB-first into a pixel stream. It also generates the frame-rate `faintPhase`, `blinkPhase` and `cursorPhase` signals that the styler consumes.

---
 rtl/styler_scheduler.sv | 176 +++++++++++++++++
 tb/tb_styler_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/styler_scheduler.sv
// Styler sequencer: fetches glyph rows per cell/scanline, styles them, serializes pixels MSB-first.
// Define STYLER_SCHED_CURSOR_PHASE_EN for an independent CURSOR_DIV cursor counter; otherwise cursorPhase follows blinkPhase.
module styler_scheduler #(
  parameter int COLS       = 80,
  parameter int ROWS       = 25,
  parameter int BLINK_DIV  = 32,
  parameter int CURSOR_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frameStart,
  input  logic        pixelEnable,
  output logic        cellReq,
  output logic [7:0]  cellCol,
  output logic [7:0]  cellRow,
  input  logic        cellAck,
  input  logic [15:0] cellBitmap,
  output logic [3:0]  styScanline,
  output logic [15:0] styBitmap,
  input  logic [15:0] styResult,
  output logic        faintPhase,
  output logic        blinkPhase,
  output logic        cursorPhase,
  output logic        pixelOut,
  output logic        frameDone,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, REQ, STYLE, WAIT, DONE} state_t;

  state_t      state;
  logic [15:0] pend;
  logic        pendValid;
  logic [15:0] shiftReg;
  logic [4:0]  bitCnt;
  logic [7:0]  blinkCnt;
  logic        loadPend;
  logic        lastCol;
  logic        lastLine;
  logic        lastRow;

  assign loadPend = pixelEnable && !frameStart && (bitCnt == 5'd0) && pendValid;
  assign lastCol  = (cellCol == 8'(COLS - 1));
  assign lastLine = (styScanline == 4'hF);
  assign lastRow  = (cellRow == 8'(ROWS - 1));

  // pendValid is set by STYLE and cleared by the shifter; the two never coincide
  // because a fetch is only issued once the previous pend has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cellReq     <= 1'b0;
      cellCol     <= 8'd0;
      cellRow     <= 8'd0;
      styScanline <= 4'd0;
      styBitmap   <= 16'd0;
      frameDone   <= 1'b0;
      pend        <= 16'd0;
      pendValid   <= 1'b0;
    end else if (frameStart) begin
      state       <= REQ;
      cellReq     <= 1'b1;
      cellCol     <= 8'd0;
      cellRow     <= 8'd0;
      styScanline <= 4'd0;
      frameDone   <= 1'b0;
      pendValid   <= 1'b0;
    end else begin
      if (loadPend) pendValid <= 1'b0;
      case (state)
        IDLE: ;
        REQ: begin
          if (cellAck) begin
            styBitmap <= cellBitmap;
            cellReq   <= 1'b0;
            state     <= STYLE;
          end
        end
        STYLE: begin
          pend      <= styResult;
          pendValid <= 1'b1;
          if (lastCol) begin
            cellCol <= 8'd0;
            if (lastLine) begin
              styScanline <= 4'd0;
              cellRow     <= lastRow ? 8'd0 : cellRow + 8'd1;
            end else begin
              styScanline <= styScanline + 4'd1;
            end
          end else begin
            cellCol <= cellCol + 8'd1;
          end
          if (lastCol && lastLine && lastRow) begin
            state     <= DONE;
            frameDone <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!pendValid) begin
            state   <= REQ;
            cellReq <= 1'b1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg <= 16'd0;
      bitCnt   <= 5'd0;
      pixelOut <= 1'b0;
      underrun <= 1'b0;
    end else if (frameStart) begin
      bitCnt   <= 5'd0;
      underrun <= 1'b0;
    end else if (pixelEnable) begin
      if (bitCnt != 5'd0) begin
        pixelOut <= shiftReg[14];
        shiftReg <= {shiftReg[14:0], 1'b0};
        bitCnt   <= bitCnt - 5'd1;
      end else if (pendValid) begin
        shiftReg <= pend;
        pixelOut <= pend[15];
        bitCnt   <= 5'd15;
      end else begin
        // Running dry outside an active frame is expected, not a fault.
        pixelOut <= 1'b0;
        if (state != DONE && state != IDLE) underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faintPhase <= 1'b0;
      blinkPhase <= 1'b0;
      blinkCnt   <= 8'd0;
    end else if (frameStart) begin
      faintPhase <= ~faintPhase;
      if (blinkCnt == 8'(BLINK_DIV - 1)) begin
        blinkCnt   <= 8'd0;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + 8'd1;
      end
    end
  end

`ifdef STYLER_SCHED_CURSOR_PHASE_EN
  logic [7:0] cursorCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursorPhase <= 1'b0;
      cursorCnt   <= 8'd0;
    end else if (frameStart) begin
      if (cursorCnt == 8'(CURSOR_DIV - 1)) begin
        cursorCnt   <= 8'd0;
        cursorPhase <= ~cursorPhase;
      end else begin
        cursorCnt <= cursorCnt + 8'd1;
      end
    end
  end
`else
  logic unusedCursorDiv;
  assign unusedCursorDiv = ^8'(CURSOR_DIV);
  assign cursorPhase     = blinkPhase;
`endif

endmodule

// File: tb/tb_styler_scheduler.sv
// Directed bench for styler_scheduler: reset, phases, frame streaming, underrun, restart, async reset.
module tb_styler_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frameStart = 1'b0;
  logic        pixelEnable = 1'b0;
  logic        cellReq;
  logic [7:0]  cellCol;
  logic [7:0]  cellRow;
  logic        cellAck = 1'b0;
  logic [15:0] cellBitmap = 16'd0;
  logic [3:0]  styScanline;
  logic [15:0] styBitmap;
  logic [15:0] styResult;
  logic        faintPhase;
  logic        blinkPhase;
  logic        cursorPhase;
  logic        pixelOut;
  logic        frameDone;
  logic        underrun;

  int nChecks = 0;
  int nErrors = 0;

  logic autoAck = 1'b0;
  int   ackDelay = 0;
  int   waitCnt = 0;
  int   nFetch = 0;
  logic [7:0] logCol [64];
  logic [7:0] logRow [64];
  logic [3:0] logScan[64];

  logic faintExp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic blinkExp [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef STYLER_SCHED_CURSOR_PHASE_EN
  logic cursorExp[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
  logic cursorExp[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

  always #5 clk = ~clk;

  // Identity styler model.
  assign styResult = styBitmap;

  styler_scheduler #(.COLS(2), .ROWS(1), .BLINK_DIV(2), .CURSOR_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .frameStart(frameStart), .pixelEnable(pixelEnable),
    .cellReq(cellReq), .cellCol(cellCol), .cellRow(cellRow), .cellAck(cellAck),
    .cellBitmap(cellBitmap), .styScanline(styScanline), .styBitmap(styBitmap),
    .styResult(styResult), .faintPhase(faintPhase), .blinkPhase(blinkPhase),
    .cursorPhase(cursorPhase), .pixelOut(pixelOut), .frameDone(frameDone),
    .underrun(underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulseFrame();
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  task automatic doReset();
    autoAck     = 1'b0;
    cellAck     = 1'b0;
    pixelEnable = 1'b0;
    frameStart  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    waitCnt  = 0;
    nFetch   = 0;
    ackDelay = 0;
  endtask

  // Memory responder: acks a pending request after ackDelay idle cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (autoAck) begin
        if (cellAck) begin
          cellAck = 1'b0;
        end else if (cellReq) begin
          if (waitCnt >= ackDelay) begin
            cellAck    = 1'b1;
            cellBitmap = 16'hA5C3;
            waitCnt    = 0;
            if (nFetch < 64) begin
              logCol[nFetch]  = cellCol;
              logRow[nFetch]  = cellRow;
              logScan[nFetch] = styScanline;
            end
            nFetch++;
          end else begin
            waitCnt++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] word;
    logic [20:0] snap;
    logic        orPix;
    logic        found;

    // Reset state and idle behaviour
    repeat (3) @(negedge clk);
    check("rst_req", cellReq, 0);
    check("rst_pos", {cellRow, cellCol, styScanline}, 0);
    check("rst_bmp", styBitmap, 0);
    check("rst_flags", {pixelOut, frameDone, underrun, faintPhase, blinkPhase, cursorPhase}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_noreq", cellReq, 0);

    // Phase counters over six frame starts
    for (int i = 0; i < 6; i++) begin
      pulseFrame();
      if (i == 0) check("first_req", {cellReq, cellCol, cellRow, styScanline}, {1'b1, 20'h0});
      check($sformatf("phase%0d", i), {faintPhase, blinkPhase, cursorPhase},
            {faintExp[i], blinkExp[i], cursorExp[i]});
    end
    repeat (3) @(negedge clk);
    check("phase_hold", {faintPhase, blinkPhase, cursorPhase}, {faintExp[5], blinkExp[5], cursorExp[5]});

    // Asynchronous reset while requesting
    check("pre_rst_req", cellReq, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", cellReq, 0);
    check("arst_pos", {cellRow, cellCol, styScanline, styBitmap}, 0);
    check("arst_flags", {pixelOut, frameDone, underrun, faintPhase, blinkPhase, cursorPhase}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_noreq", cellReq, 0);

    // Full frame, COLS=2 ROWS=1, prompt acks, continuous pixels
    doReset();
    autoAck = 1'b1;
    pulseFrame();
    repeat (2) @(negedge clk);
    pixelEnable = 1'b1;
    for (int c = 0; c < 32; c++) begin
      word = 16'd0;
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        word = {word[14:0], pixelOut};
      end
      check($sformatf("cell%0d_pix", c), word, 16'hA5C3);
      if (c == 4) check("mid_frameDone", frameDone, 0);
    end
    check("frame_fetches", nFetch, 32);
    check("frame_done", frameDone, 1);
    check("frame_underrun", underrun, 0);
    for (int k = 0; k < 32; k++)
      check($sformatf("fetch%0d_pos", k), {logRow[k], logScan[k], logCol[k]},
            {8'd0, 4'(k / 2), 8'(k % 2)});
    orPix = 1'b0;
    repeat (20) begin
      @(negedge clk);
      orPix = orPix | pixelOut;
    end
    check("done_pix_zero", orPix, 0);
    check("done_underrun", underrun, 0);

    // Delayed second ack starves the shifter
    doReset();
    autoAck = 1'b1;
    pulseFrame();
    repeat (2) @(negedge clk);
    ackDelay    = 40;
    pixelEnable = 1'b1;
    word = 16'd0;
    snap = 21'd0;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      word = {word[14:0], pixelOut};
      if (b == 5) snap = {cellReq, cellCol, cellRow, styScanline};
    end
    check("starve_first_pix", word, 16'hA5C3);
    check("starve_no_underrun_yet", underrun, 0);
    check("starve_snap", snap, {1'b1, 8'd1, 8'd0, 4'd0});
    @(negedge clk);
    check("starve_underrun", underrun, 1);
    check("starve_pix0", pixelOut, 0);
    orPix = 1'b0;
    repeat (10) begin
      @(negedge clk);
      orPix = orPix | pixelOut;
    end
    check("starve_pix_zero", orPix, 0);
    check("req_stable", {cellReq, cellCol, cellRow, styScanline}, {1'b1, 8'd1, 8'd0, 4'd0});
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (nFetch >= 2) found = 1'b1;
    end
    check("starve_ack_seen", found, 1);

    // Mid-line restart at col 1, scanline 5
    doReset();
    autoAck = 1'b1;
    pulseFrame();
    repeat (2) @(negedge clk);
    pixelEnable = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 1000 && !found; t++) begin
      @(negedge clk);
      if (dut.pendValid && !cellReq && cellCol == 8'd1 && styScanline == 4'd5) found = 1'b1;
    end
    check("midline_found", found, 1);
    frameStart  = 1'b1;
    pixelEnable = 1'b0;
    nFetch      = 0;
    @(negedge clk);
    frameStart = 1'b0;
    check("restart_pendValid", dut.pendValid, 0);
    check("restart_req", {cellReq, cellCol, cellRow, styScanline}, {1'b1, 20'h0});
    check("restart_underrun", underrun, 0);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (nFetch >= 1) found = 1'b1;
    end
    check("restart_fetch_seen", found, 1);
    check("restart_fetch_pos", {logRow[0], logScan[0], logCol[0]}, 20'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
